// File: rtl/systolic_matmul3x3.sv
// 3x3 output-stationary systolic matrix multiplier: P = A x B on skewed
// row/column streams, one accumulator per PE presented directly on Pij.
//
// state  | meaning
// S_IDLE | waiting for a start rising edge; accumulators, pipeline and Done hold
// S_RUN  | steps k=1..6 of a run (k=0 is the trigger edge taken from S_IDLE)
module systolic_matmul3x3 #(
  parameter int DATAWIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATAWIDTH-1:0]   A0,
  input  logic [DATAWIDTH-1:0]   A1,
  input  logic [DATAWIDTH-1:0]   A2,
  input  logic [DATAWIDTH-1:0]   B0,
  input  logic [DATAWIDTH-1:0]   B1,
  input  logic [DATAWIDTH-1:0]   B2,
  output logic [2*DATAWIDTH-1:0] P11,
  output logic [2*DATAWIDTH-1:0] P12,
  output logic [2*DATAWIDTH-1:0] P13,
  output logic [2*DATAWIDTH-1:0] P21,
  output logic [2*DATAWIDTH-1:0] P22,
  output logic [2*DATAWIDTH-1:0] P23,
  output logic [2*DATAWIDTH-1:0] P31,
  output logic [2*DATAWIDTH-1:0] P32,
  output logic [2*DATAWIDTH-1:0] P33,
  output logic                   Done
);

  localparam int PW = 2 * DATAWIDTH;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              state, state_nxt;
  logic [2:0]          step, step_nxt;
  logic                start_q;
  logic                active;
  logic                done_set;
  logic                feed;
  logic                done_q;

  logic [DATAWIDTH-1:0] a_port [3];
  logic [DATAWIDTH-1:0] b_port [3];
  logic [DATAWIDTH-1:0] a_pipe [3][2];
  logic [DATAWIDTH-1:0] b_pipe [2][3];
  logic [DATAWIDTH-1:0] a_in   [3][3];
  logic [DATAWIDTH-1:0] b_in   [3][3];
  logic [PW-1:0]        prod   [3][3];
  logic [PW-1:0]        acc    [3][3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      step    <= '0;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      step    <= step_nxt;
      start_q <= start;
    end
  end

  // step stays 0 while idle, so the trigger edge naturally sees k=0
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    active    = 1'b0;
    done_set  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !start_q) begin
          state_nxt = S_RUN;
          step_nxt  = 3'd1;
          active    = 1'b1;
        end
      end
      S_RUN: begin
        active = 1'b1;
        if (step == 3'd6) begin
          state_nxt = S_IDLE;
          step_nxt  = '0;
          done_set  = 1'b1;
        end else begin
          step_nxt = step + 3'd1;
        end
      end
    endcase
  end

  assign feed = active && (step <= 3'd4);

  always_comb begin
    a_port[0] = feed ? A0 : '0;
    a_port[1] = feed ? A1 : '0;
    a_port[2] = feed ? A2 : '0;
    b_port[0] = feed ? B0 : '0;
    b_port[1] = feed ? B1 : '0;
    b_port[2] = feed ? B2 : '0;
  end

  for (genvar i = 0; i < 3; i++) begin : g_row
    for (genvar j = 0; j < 3; j++) begin : g_col
      logic [PW-1:0] acc_r;

      if (j == 0) begin : g_a_edge
        assign a_in[i][j] = a_port[i];
      end else begin : g_a_link
        assign a_in[i][j] = a_pipe[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_in[i][j] = b_port[j];
      end else begin : g_b_link
        assign b_in[i][j] = b_pipe[i-1][j];
      end

      assign prod[i][j] = {{DATAWIDTH{1'b0}}, a_in[i][j]} * {{DATAWIDTH{1'b0}}, b_in[i][j]};

      // the k=0 clear drops the previous run's result in the same edge as the first term
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          acc_r <= '0;
        else if (active)
          acc_r <= ((step == 3'd0) ? '0 : acc_r) + prod[i][j];
      end
      assign acc[i][j] = acc_r;

      // right-most a_out and bottom-most b_out have no consumer, so they are not kept
      if (j < 2) begin : g_a_reg
        logic [DATAWIDTH-1:0] a_r;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst)
            a_r <= '0;
          else if (active)
            a_r <= a_in[i][j];
        end
        assign a_pipe[i][j] = a_r;
      end

      if (i < 2) begin : g_b_reg
        logic [DATAWIDTH-1:0] b_r;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst)
            b_r <= '0;
          else if (active)
            b_r <= b_in[i][j];
        end
        assign b_pipe[i][j] = b_r;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      done_q <= 1'b0;
    else if (active && (step == 3'd0))
      done_q <= 1'b0;
    else if (done_set)
      done_q <= 1'b1;
  end

  assign Done = done_q;
  assign P11  = acc[0][0];
  assign P12  = acc[0][1];
  assign P13  = acc[0][2];
  assign P21  = acc[1][0];
  assign P22  = acc[1][1];
  assign P23  = acc[1][2];
  assign P31  = acc[2][0];
  assign P32  = acc[2][1];
  assign P33  = acc[2][2];

endmodule

// File: tb/tb_systolic_matmul3x3.sv
// Self-checking bench for systolic_matmul3x3: table vectors, random matrices
// against a plain matrix-product reference, and start/reset corner sequences.
module tb_systolic_matmul3x3;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] A0, A1, A2, B0, B1, B2;
  logic [15:0]   P11, P12, P13, P21, P22, P23, P31, P32, P33;
  logic          Done;

  always #5 clk = ~clk;

  systolic_matmul3x3 #(.DATAWIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A0(A0), .A1(A1), .A2(A2), .B0(B0), .B1(B1), .B2(B2),
    .P11(P11), .P12(P12), .P13(P13),
    .P21(P21), .P22(P22), .P23(P23),
    .P31(P31), .P32(P32), .P33(P33),
    .Done(Done)
  );

  // matrices stored row-major: element [r][c] at index r*3+c
  typedef struct packed {
    logic [8:0][7:0]  a;
    logic [8:0][7:0]  b;
    logic [8:0][15:0] p;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl [3];

  int main_m [9] = '{3, 4, 2, 2, 5, 3, 3, 2, 5};
  int main_p [9] = '{23, 36, 28, 25, 39, 34, 28, 32, 37};
  int id_b   [9] = '{7, 1, 9, 200, 0, 13, 42, 255, 6};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pval(input int i, input int j);
    case (i * 3 + j)
      0: return P11;
      1: return P12;
      2: return P13;
      3: return P21;
      4: return P22;
      5: return P23;
      6: return P31;
      7: return P32;
      default: return P33;
    endcase
  endfunction

  // sum of the product terms A[i][m]*B[m][j] that have arrived by step k (term m lands at i+j+m)
  function automatic int partial(input vec_t v, input int i, input int j, input int k);
    int s = 0;
    for (int m = 0; m < 3; m++)
      if (i + j + m <= k)
        s += int'(v.a[i*3+m]) * int'(v.b[m*3+j]);
    return s & 32'hFFFF;
  endfunction

  // k=0..4: skewed schedule; k=5,6: garbage the DUT must ignore; k>=7: zeros
  task automatic set_ports(input vec_t v, input int k);
    int av [3];
    int bv [3];
    for (int i = 0; i < 3; i++) begin
      if (k == 5 || k == 6) begin
        av[i] = int'($urandom_range(0, 255));
        bv[i] = int'($urandom_range(0, 255));
      end else if (k <= 4 && k >= i && k <= i + 2) begin
        av[i] = int'(v.a[i*3 + (k-i)]);
        bv[i] = int'(v.b[(k-i)*3 + i]);
      end else begin
        av[i] = 0;
        bv[i] = 0;
      end
    end
    A0 = 8'(av[0]); A1 = 8'(av[1]); A2 = 8'(av[2]);
    B0 = 8'(bv[0]); B1 = 8'(bv[1]); B2 = 8'(bv[2]);
  endtask

  task automatic check_partial(input vec_t v, input int k, input string tag);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("%s P%0d%0d k%0d", tag, i+1, j+1, k), 32'(pval(i, j)), 32'(partial(v, i, j, k)));
  endtask

  task automatic check_final(input vec_t v, input string tag);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("%s final P%0d%0d", tag, i+1, j+1), 32'(pval(i, j)), 32'(v.p[i*3+j]));
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("%s P%0d%0d", tag, i+1, j+1), 32'(pval(i, j)), 32'd0);
    chk({tag, " done"}, 32'(Done), 32'd0);
  endtask

  // hold: keep start high afterwards; tog: re-raise start while busy
  task automatic run(input vec_t v, input bit hold, input bit tog, input string tag);
    @(negedge clk);
    start = 1'b0;
    set_ports(v, 7);
    @(negedge clk);
    start = 1'b1;
    set_ports(v, 0);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin
        @(negedge clk);
        set_ports(v, k);
        if (k == 2 && !hold) start = 1'b0;
        if (k == 3 && tog)   start = 1'b1;
      end
      @(posedge clk);
      #1;
      chk($sformatf("%s done k%0d", tag, k), 32'(Done), 32'(k == 6));
      check_partial(v, k, tag);
    end
    @(negedge clk);
    set_ports(v, 7);
    check_final(v, tag);
    chk({tag, " done held"}, 32'(Done), 32'd1);
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int n = 0; n < 9; n++) begin
      v.a[n] = 8'($urandom_range(0, 255));
      v.b[n] = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        v.p[i*3+j] = 16'(partial(v, i, j, 6));
    return v;
  endfunction

  initial begin
    vec_t v;

    for (int n = 0; n < 9; n++) begin
      tbl[0].a[n] = 8'(main_m[n]);
      tbl[0].b[n] = 8'(main_m[n]);
      tbl[0].p[n] = 16'(main_p[n]);
      tbl[1].a[n] = (n % 4 == 0) ? 8'd1 : 8'd0;
      tbl[1].b[n] = 8'(id_b[n]);
      tbl[1].p[n] = 16'(id_b[n]);
      tbl[2].a[n] = 8'd255;
      tbl[2].b[n] = 8'd255;
      tbl[2].p[n] = 16'd64003;
    end

    rst = 1'b0;
    start = 1'b0;
    A0 = '0; A1 = '0; A2 = '0; B0 = '0; B1 = '0; B2 = '0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int t = 0; t < 3; t++)
      run(tbl[t], 1'b0, 1'b0, $sformatf("tbl%0d", t));

    for (int n = 0; n < 6; n++) begin
      v = rand_vec();
      run(v, 1'b0, 1'b0, $sformatf("rand%0d", n));
    end

    // start held high for two run lengths must not retrigger
    run(tbl[0], 1'b1, 1'b0, "hold");
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      set_ports(tbl[0], 5);
    end
    set_ports(tbl[0], 7);
    check_final(tbl[0], "hold idle");
    chk("hold idle done", 32'(Done), 32'd1);
    run(tbl[1], 1'b0, 1'b0, "rerun");

    v = rand_vec();
    run(v, 1'b0, 1'b1, "busytog");

    // reset asserted mid-run at k=3
    @(negedge clk);
    start = 1'b0;
    set_ports(tbl[0], 7);
    @(negedge clk);
    start = 1'b1;
    set_ports(tbl[0], 0);
    @(posedge clk);
    #1;
    check_partial(tbl[0], 0, "abort");
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      set_ports(tbl[0], k);
      start = 1'b0;
      @(posedge clk);
      #1;
      check_partial(tbl[0], k, "abort");
    end
    @(negedge clk);
    set_ports(tbl[0], 3);
    #1;
    rst = 1'b0;
    #1;
    check_zero("abort rst");
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      set_ports(tbl[0], 5);
    end
    set_ports(tbl[0], 7);
    check_zero("after rst");
    run(tbl[0], 1'b0, 1'b0, "fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
